// File: rtl/bus_responder_if.sv
// CPU-to-memory access bus: the CPU (master) issues requests, the responder (slave)
// answers with a ready pulse, read data and the timer interrupt line.
interface bus_responder_if;
  logic        req;
  logic        mem_rw;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;
  logic        irq;

  modport master (output req, mem_rw, addr, wdata, input rdata, ready, irq);
  modport slave  (input req, mem_rw, addr, wdata, output rdata, ready, irq);
endinterface

// File: rtl/bus_responder.sv
// Memory-side target: mirrored RAM, read-only vector bytes and an I/O page holding
// an 8-bit interval timer. Every accepted access gets one ready pulse after WAIT cycles.
module bus_responder #(
  parameter int          RAM_AW    = 11,
  parameter int          WAIT      = 1,
  parameter logic [7:0]  IO_PAGE   = 8'hFE,
  parameter logic [15:0] RESET_VEC = 16'h0200,
  parameter logic [15:0] IRQ_VEC   = 16'h0300
) (
  input  logic            i_clk,
  input  logic            i_rst,
  bus_responder_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_t      r_state, w_state_next;
  logic [3:0]  r_wcnt, w_wcnt_next;
  logic        r_rw;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [1:0]  r_ctrl;
  logic [7:0]  r_reload;
  logic [7:0]  r_count;
  logic        r_pending;
  logic        r_irq;
  logic [7:0]  r_mem [2**RAM_AW];

  logic        w_accept;
  logic        w_enter_resp;
  logic [15:0] w_addr;
  logic        w_rw;
  logic        w_is_vec;
  logic        w_is_io;
  logic [7:0]  w_rd;
  logic        w_commit;
  logic        w_wr_ram;
  logic        w_wr_ctrl;
  logic        w_wr_reload;
  logic        w_wr_ack;
  logic        w_expire;

  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    w_accept     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_accept = 1'b1;
          if (WAIT == 0) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
            w_wcnt_next  = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_wcnt == 4'd0) w_state_next = S_RESP;
        else                w_wcnt_next  = r_wcnt - 4'd1;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // With WAIT=0 the response is entered on the accepting edge, so decode the live bus then.
  assign w_addr       = (r_state == S_IDLE) ? bus.addr   : r_addr;
  assign w_rw         = (r_state == S_IDLE) ? bus.mem_rw : r_rw;
  assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);
  assign w_is_vec     = (w_addr >= 16'hFFFA);
  assign w_is_io      = (w_addr[15:8] == IO_PAGE);

  always_comb begin
    w_rd = 8'h00;
    if (w_is_vec) begin
      if (w_addr[2:1] == 2'b10) w_rd = w_addr[0] ? RESET_VEC[15:8] : RESET_VEC[7:0];
      else                      w_rd = w_addr[0] ? IRQ_VEC[15:8]   : IRQ_VEC[7:0];
    end else if (w_is_io) begin
      case (w_addr[7:0])
        8'h00:   w_rd = {r_pending, 5'b00000, r_ctrl};
        8'h01:   w_rd = r_reload;
        8'h02:   w_rd = r_count;
        default: w_rd = 8'h00;
      endcase
    end else begin
      w_rd = r_mem[w_addr[RAM_AW-1:0]];
    end
  end

  assign w_commit    = (r_state == S_RESP) && !r_rw;
  assign w_wr_ram    = w_commit && !w_is_vec && !w_is_io;
  assign w_wr_ctrl   = w_commit && !w_is_vec && w_is_io && (r_addr[7:0] == 8'h00);
  assign w_wr_reload = w_commit && !w_is_vec && w_is_io && (r_addr[7:0] == 8'h01);
  assign w_wr_ack    = w_commit && !w_is_vec && w_is_io && (r_addr[7:0] == 8'h03);
  assign w_expire    = r_ctrl[0] && (r_count == 8'h00);

  always_ff @(posedge i_clk) begin
    if (w_wr_ram) r_mem[r_addr[RAM_AW-1:0]] <= r_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= 4'd0;
      r_rw    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
      if (w_accept) begin
        r_rw    <= bus.mem_rw;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (w_enter_resp && w_rw) r_rdata <= w_rd;
    end
  end

  // A RELOAD write overrides the timer step; an expiry beats a coincident ACK.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ctrl    <= 2'b00;
      r_reload  <= 8'hFF;
      r_count   <= 8'hFF;
      r_pending <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= r_wdata[1:0];
      if (w_wr_reload) begin
        r_reload <= r_wdata;
        r_count  <= r_wdata;
      end else if (r_ctrl[0]) begin
        r_count <= w_expire ? r_reload : r_count - 8'd1;
      end
      if (w_expire)      r_pending <= 1'b1;
      else if (w_wr_ack) r_pending <= 1'b0;
      r_irq <= r_pending & r_ctrl[1];
    end
  end

  assign bus.ready = (r_state == S_RESP);
  assign bus.rdata = r_rdata;
  assign bus.irq   = r_irq;
endmodule
